// File: rtl/ap_acc_pkg.sv
// Shared types, default widths and saturation limits for the product accumulator.
package ap_acc_pkg;

    localparam int unsigned PW_DEF    = 24;
    localparam int unsigned AW_DEF    = 32;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } acc_st_t;

    // Two's-complement limits of an aw-bit signed value, returned in the low aw bits.
    function automatic logic [63:0] sat_max(input int unsigned aw);
        return (64'(1) << (aw - 1)) - 64'(1);
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned aw);
        return 64'(1) << (aw - 1);
    endfunction

endpackage

// File: rtl/ap_sat_add.sv
// Combinational signed saturating adder; ovf flags a clamped result.
module ap_sat_add
    import ap_acc_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic [AW-1:0] a_i,
    input  logic [AW-1:0] b_i,
    output logic [AW-1:0] sum_o,
    output logic          ovf_o
);

    localparam logic [AW-1:0] MAX_V = AW'(sat_max(AW));
    localparam logic [AW-1:0] MIN_V = AW'(sat_min(AW));

    logic [AW:0] s_wide;

    // One guard bit: the top two bits disagree exactly when the true sum is out of range.
    always_comb begin
        s_wide = {a_i[AW-1], a_i} + {b_i[AW-1], b_i};
        ovf_o  = s_wide[AW] ^ s_wide[AW-1];
        sum_o  = s_wide[AW-1:0];
        if (ovf_o) begin
            sum_o = s_wide[AW] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/ap_prod_acc.sv
// Frame accumulator for signed multiplier products with valid/ready on both sides
// and a held, saturating result register.
module ap_prod_acc
    import ap_acc_pkg::*;
#(
    parameter int unsigned PW    = PW_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [PW-1:0]    prod_i,
    input  logic             prod_vld_i,
    input  logic             prod_last_i,
    output logic             prod_rdy_o,
    input  logic             clr_i,
    output logic [AW-1:0]    acc_o,
    output logic [CNT_W-1:0] acc_cnt_o,
    output logic             acc_sat_o,
    output logic             acc_vld_o,
    input  logic             acc_rdy_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    acc_st_t          state_q;
    logic             live_q;
    logic [AW-1:0]    run_sum_q;
    logic [CNT_W-1:0] run_cnt_q;
    logic             run_sat_q;
    logic [AW-1:0]    acc_q;
    logic [CNT_W-1:0] acc_cnt_q;
    logic             acc_sat_q;
    logic             acc_vld_q;

    logic [AW-1:0]    base_sum;
    logic [CNT_W-1:0] base_cnt;
    logic [AW-1:0]    prod_ext;
    logic [AW-1:0]    sum_d;
    logic [CNT_W-1:0] cnt_d;
    logic             sat_d;
    logic             ovf;
    logic             beat_acc;

    // Ready is combinational on acc_rdy so a result handshake and a new beat share a cycle.
    always_comb begin
        prod_rdy_o = live_q & (~acc_vld_q | acc_rdy_i) & ~clr_i;
        beat_acc   = prod_vld_i & prod_rdy_o;
        base_sum   = (state_q == RUN) ? run_sum_q : '0;
        base_cnt   = (state_q == RUN) ? run_cnt_q : '0;
        prod_ext   = AW'($signed(prod_i));
        cnt_d      = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + CNT_W'(1);
        sat_d      = (state_q == RUN) & run_sat_q | ovf;
    end

    ap_sat_add #(
        .AW (AW)
    ) u_sat_add (
        .a_i   (base_sum),
        .b_i   (prod_ext),
        .sum_o (sum_d),
        .ovf_o (ovf)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            live_q    <= 1'b0;
            run_sum_q <= '0;
            run_cnt_q <= '0;
            run_sat_q <= 1'b0;
            acc_q     <= '0;
            acc_cnt_q <= '0;
            acc_sat_q <= 1'b0;
            acc_vld_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (acc_vld_q && acc_rdy_i) begin
                acc_vld_q <= 1'b0;
            end
            if (clr_i) begin
                state_q   <= IDLE;
                run_sum_q <= '0;
                run_cnt_q <= '0;
                run_sat_q <= 1'b0;
            end else if (beat_acc) begin
                if (prod_last_i) begin
                    // Frame closes: publish the result and restart the running sum.
                    acc_q     <= sum_d;
                    acc_cnt_q <= cnt_d;
                    acc_sat_q <= sat_d;
                    acc_vld_q <= 1'b1;
                    state_q   <= IDLE;
                    run_sum_q <= '0;
                    run_cnt_q <= '0;
                    run_sat_q <= 1'b0;
                end else begin
                    state_q   <= RUN;
                    run_sum_q <= sum_d;
                    run_cnt_q <= cnt_d;
                    run_sat_q <= sat_d;
                end
            end
        end
    end

    assign acc_o     = acc_q;
    assign acc_cnt_o = acc_cnt_q;
    assign acc_sat_o = acc_sat_q;
    assign acc_vld_o = acc_vld_q;

endmodule

// File: tb/tb_ap_prod_acc.sv
// Directed bench for ap_prod_acc: default-width and AW=26 instances share one stimulus stream.
module tb_ap_prod_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] prod;
    logic        prod_vld;
    logic        prod_last;
    logic        clr;
    logic        acc_rdy;

    logic        prod_rdy;
    logic [31:0] acc;
    logic [7:0]  acc_cnt;
    logic        acc_sat;
    logic        acc_vld;

    logic        prod_rdy26;
    logic [25:0] acc26;
    logic [7:0]  acc_cnt26;
    logic        acc_sat26;
    logic        acc_vld26;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ap_prod_acc u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .prod_i      (prod),
        .prod_vld_i  (prod_vld),
        .prod_last_i (prod_last),
        .prod_rdy_o  (prod_rdy),
        .clr_i       (clr),
        .acc_o       (acc),
        .acc_cnt_o   (acc_cnt),
        .acc_sat_o   (acc_sat),
        .acc_vld_o   (acc_vld),
        .acc_rdy_i   (acc_rdy)
    );

    ap_prod_acc #(
        .AW (26)
    ) u_dut26 (
        .clk_i       (clk),
        .rst_i       (rst),
        .prod_i      (prod),
        .prod_vld_i  (prod_vld),
        .prod_last_i (prod_last),
        .prod_rdy_o  (prod_rdy26),
        .clr_i       (clr),
        .acc_o       (acc26),
        .acc_cnt_o   (acc_cnt26),
        .acc_sat_o   (acc_sat26),
        .acc_vld_o   (acc_vld26),
        .acc_rdy_i   (acc_rdy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted, with a bounded wait.
    task automatic send(input logic [23:0] p, input logic last);
        int n = 0;
        prod      = p;
        prod_last = last;
        prod_vld  = 1'b1;
        while (!prod_rdy && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'(n), 64'(0));
        tick();
        prod_vld  = 1'b0;
        prod_last = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_acc"}, 64'(acc), 64'(0));
        chk({tag, "_cnt"}, 64'(acc_cnt), 64'(0));
        chk({tag, "_sat"}, 64'(acc_sat), 64'(0));
        chk({tag, "_vld"}, 64'(acc_vld), 64'(0));
        chk({tag, "_rdy"}, 64'(prod_rdy), 64'(0));
    endtask

    initial begin
        rst       = 1'b1;
        prod      = '0;
        prod_vld  = 1'b0;
        prod_last = 1'b0;
        clr       = 1'b0;
        acc_rdy   = 1'b0;

        // Reset and release
        #12;
        chk_zero("rst");
        tick();
        rst = 1'b0;
        #1;
        chk("rdy_after_release", 64'(prod_rdy), 64'(0));
        tick();
        chk("rdy_one_clk_later", 64'(prod_rdy), 64'(1));

        // Basic three-beat frame
        send(24'(100), 1'b0);
        send(24'(-250), 1'b0);
        send(24'(4194304), 1'b1);
        chk("f1_acc", 64'($signed(acc)), 64'(4194154));
        chk("f1_cnt", 64'(acc_cnt), 64'(3));
        chk("f1_sat", 64'(acc_sat), 64'(0));
        chk("f1_vld", 64'(acc_vld), 64'(1));

        // Backpressure, then handshake with a 1-beat frame in the same cycle
        prod      = 24'(7);
        prod_last = 1'b1;
        prod_vld  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rdy", 64'(prod_rdy), 64'(0));
            chk("bp_acc", 64'($signed(acc)), 64'(4194154));
            tick();
        end
        chk("bp_vld", 64'(acc_vld), 64'(1));
        acc_rdy = 1'b1;
        #1;
        chk("bp_rdy_release", 64'(prod_rdy), 64'(1));
        tick();
        prod_vld  = 1'b0;
        prod_last = 1'b0;
        chk("b2b_vld", 64'(acc_vld), 64'(1));
        chk("b2b_acc", 64'($signed(acc)), 64'(7));
        chk("b2b_cnt", 64'(acc_cnt), 64'(1));
        tick();
        chk("b2b_vld_drop", 64'(acc_vld), 64'(0));

        // Saturation at AW=26; the 32-bit instance holds the exact sums
        for (int i = 0; i < 8; i++) send(24'(4194304), i == 7);
        chk("pos8_acc26", 64'($signed(acc26)), 64'(33554431));
        chk("pos8_sat26", 64'(acc_sat26), 64'(1));
        chk("pos8_acc32", 64'($signed(acc)), 64'(33554432));
        chk("pos8_sat32", 64'(acc_sat), 64'(0));
        chk("pos8_cnt", 64'(acc_cnt26), 64'(8));
        for (int i = 0; i < 8; i++) send(24'(-4194304), i == 7);
        chk("neg8_acc26", 64'($signed(acc26)), 64'(-33554432));
        chk("neg8_sat26", 64'(acc_sat26), 64'(0));
        for (int i = 0; i < 9; i++) send(24'(-4194304), i == 8);
        chk("neg9_acc26", 64'($signed(acc26)), 64'(-33554432));
        chk("neg9_sat26", 64'(acc_sat26), 64'(1));
        chk("neg9_cnt", 64'(acc_cnt26), 64'(9));
        chk("neg9_acc32", 64'($signed(acc)), 64'(-37748736));

        // clr drops the partial frame and blocks the beat offered with it
        send(24'(1000), 1'b0);
        send(24'(2000), 1'b0);
        clr       = 1'b1;
        prod      = 24'(9);
        prod_last = 1'b1;
        prod_vld  = 1'b1;
        #1;
        chk("clr_rdy", 64'(prod_rdy), 64'(0));
        tick();
        clr = 1'b0;
        send(24'(5), 1'b1);
        chk("clr_acc", 64'($signed(acc)), 64'(5));
        chk("clr_cnt", 64'(acc_cnt), 64'(1));
        chk("clr_sat", 64'(acc_sat), 64'(0));

        // Reset with a result pending
        send(24'(123), 1'b0);
        send(24'(456), 1'b0);
        send(24'(1), 1'b1);
        acc_rdy = 1'b0;
        chk("pre_rst_acc", 64'($signed(acc)), 64'(580));
        chk("pre_rst_vld", 64'(acc_vld), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_vld");
        tick();
        rst     = 1'b0;
        acc_rdy = 1'b1;

        // Reset mid-frame discards the running sum
        send(24'(10), 1'b0);
        send(24'(20), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_run");
        tick();
        rst = 1'b0;
        send(24'(42), 1'b1);
        chk("post_rst_acc", 64'($signed(acc)), 64'(42));
        chk("post_rst_cnt", 64'(acc_cnt), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
